// File: rtl/adc_interface_pkg.sv
// Shared frame timing constants and FSM state type for the ADC serial interface.
// Optional build macro ADC_TEST_PATTERN_EN is consumed by adc_deserializer.
package adc_interface_pkg;

   localparam int FRAME_CYCLES = 210;
   localparam int CONV_CYCLES  = 140;
   localparam int SCK_PERIOD   = 4;
   localparam int DATA_W       = 16;

   localparam int CNT_W    = $clog2(FRAME_CYCLES);
   localparam int SCK_PH_W = $clog2(SCK_PERIOD);

   localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_CYCLES - 1);
   localparam logic [CNT_W-1:0] READ_START = CNT_W'(CONV_CYCLES);
   localparam logic [CNT_W-1:0] READ_END   = CNT_W'(CONV_CYCLES + DATA_W * SCK_PERIOD);
   // The word is complete one cycle before the READ window closes.
   localparam logic [CNT_W-1:0] LOAD_CYCLE = CNT_W'(CONV_CYCLES + DATA_W * SCK_PERIOD - 1);

   localparam logic [SCK_PH_W-1:0] SCK_HIGH_PH = SCK_PH_W'(SCK_PERIOD / 2);

   typedef enum logic [1:0] {
      CONV,
      READ,
      WAIT
   } adc_state_t;

endpackage

// File: rtl/adc_deserializer.sv
// MSB-first shift register plus output word latch for the ADC serial stream.
// With ADC_TEST_PATTERN_EN defined, sdo is ignored and a strobe counter is latched instead.
module adc_deserializer
   import adc_interface_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              sample_en,
   input  logic              load_en,
   input  logic              sdo,
   output logic [DATA_W-1:0] word
);

   logic [DATA_W-1:0] word_reg;

`ifdef ADC_TEST_PATTERN_EN
   logic [DATA_W-1:0] pattern_reg;
   logic              unused_inputs;

   assign unused_inputs = &{1'b0, sample_en, sdo};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pattern_reg <= '0;
         word_reg    <= '0;
      end else if (load_en) begin
         word_reg    <= pattern_reg;
         pattern_reg <= pattern_reg + 1'b1;
      end
   end
`else
   logic [DATA_W-1:0] shift_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift_reg <= '0;
         word_reg  <= '0;
      end else begin
         if (sample_en) begin
            shift_reg <= {shift_reg[DATA_W-2:0], sdo};
         end
         if (load_en) begin
            word_reg <= shift_reg;
         end
      end
   end
`endif

   assign word = word_reg;

endmodule

// File: rtl/adc_interface.sv
// ADC conversion/readout sequencer: 210-cycle frame, CNV pulse, 16-bit SCK burst, word strobe.
// Build macro ADC_TEST_PATTERN_EN (see adc_deserializer) replaces sdo data with a counter.
module adc_interface
   import adc_interface_pkg::*;
(
   input  logic              clk210_p,
   input  logic              reset_p,
   output logic              cnv_p,
   output logic              sck_p,
   input  logic              sdo_p,
   output logic              adc_data_received_p,
   output logic [DATA_W-1:0] adc_data_in_p
);

   logic                running_reg;
   logic [CNT_W-1:0]    frame_cnt_reg;
   logic [CNT_W-1:0]    frame_cnt_next;
   adc_state_t          state_reg;
   logic                cnv_reg;
   logic                sck_reg;
   logic                strobe_reg;
   logic                in_read_next;
   logic [SCK_PH_W-1:0] sck_phase_next;
   logic                sample_en;
   logic                load_en;

   // The first edge after reset lands on cycle 0 instead of advancing past it.
   always_comb begin
      if (!running_reg || frame_cnt_reg == FRAME_LAST) begin
         frame_cnt_next = '0;
      end else begin
         frame_cnt_next = frame_cnt_reg + 1'b1;
      end
   end

   // Outputs are registered, so all decode looks at the cycle being entered.
   assign in_read_next   = (frame_cnt_next >= READ_START) && (frame_cnt_next < READ_END);
   assign sck_phase_next = frame_cnt_next[SCK_PH_W-1:0] - READ_START[SCK_PH_W-1:0];
   assign sample_en      = in_read_next && (sck_phase_next == SCK_HIGH_PH);
   assign load_en        = (frame_cnt_next == LOAD_CYCLE);

   always_ff @(posedge clk210_p or negedge reset_p) begin
      if (!reset_p) begin
         running_reg   <= 1'b0;
         frame_cnt_reg <= '0;
         state_reg     <= CONV;
         cnv_reg       <= 1'b0;
         sck_reg       <= 1'b0;
         strobe_reg    <= 1'b0;
      end else begin
         running_reg   <= 1'b1;
         frame_cnt_reg <= frame_cnt_next;
         strobe_reg    <= load_en;
         case (state_reg)
            CONV: begin
               if (frame_cnt_next == READ_START) begin
                  state_reg <= READ;
                  cnv_reg   <= 1'b0;
                  sck_reg   <= 1'b0;
               end else begin
                  cnv_reg   <= 1'b1;
                  sck_reg   <= 1'b0;
               end
            end
            READ: begin
               cnv_reg <= 1'b0;
               if (frame_cnt_next == READ_END) begin
                  state_reg <= WAIT;
                  sck_reg   <= 1'b0;
               end else begin
                  sck_reg   <= (sck_phase_next >= SCK_HIGH_PH);
               end
            end
            default: begin
               sck_reg <= 1'b0;
               if (frame_cnt_next == '0) begin
                  state_reg <= CONV;
                  cnv_reg   <= 1'b1;
               end else begin
                  cnv_reg   <= 1'b0;
               end
            end
         endcase
      end
   end

   adc_deserializer u_deserializer (
      .clk       (clk210_p),
      .rst_n     (reset_p),
      .sample_en (sample_en),
      .load_en   (load_en),
      .sdo       (sdo_p),
      .word      (adc_data_in_p)
   );

   assign cnv_p               = cnv_reg;
   assign sck_p               = sck_reg;
   assign adc_data_received_p = strobe_reg;

endmodule

// File: tb/tb_adc_interface.sv
// Self-checking bench for adc_interface: frame table plus a cycle-level reference model.
// Honours ADC_TEST_PATTERN_EN for the expected data words.
`timescale 1ns/1ps
module tb_adc_interface;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b1;
   logic        sdo   = 1'b0;
   logic        cnv;
   logic        sck;
   logic        strobe;
   logic [15:0] data;

   adc_interface dut (
      .clk210_p            (clk),
      .reset_p             (rst_n),
      .cnv_p               (cnv),
      .sck_p               (sck),
      .sdo_p               (sdo),
      .adc_data_received_p (strobe),
      .adc_data_in_p       (data)
   );

   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;

   // Reference model state: frame cycle of the outputs currently visible.
   int          cyc      = -1;
   logic [15:0] cur_word = '0;
   logic [15:0] exp_data = '0;
   logic [15:0] tp_cnt   = '0;

   typedef struct {
      logic [15:0] word;
      int          reset_at;
      logic [15:0] exp_word;
   } vec_t;

   vec_t vecs[9];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cyc      = -1;
         exp_data = '0;
         tp_cnt   = '0;
      end else begin
         cyc = (cyc + 1) % 210;
         if (cyc == 203) begin
`ifdef ADC_TEST_PATTERN_EN
            exp_data = tp_cnt;
            tp_cnt   = tp_cnt + 16'd1;
`else
            exp_data = cur_word;
`endif
         end
      end
   end

   // ADC model: bit k held over the whole k-th SCK period, i.e. changes after SCK falls.
   always @(negedge clk) begin
      if (rst_n && cyc >= 140 && cyc < 204)
         sdo = cur_word[15 - (cyc - 140) / 4];
      else if (cur_word == 16'hFFFF)
         sdo = 1'b1;
      else
         sdo = 1'($urandom);
   end

   int   rises         = 0;
   int   strobes       = 0;
   int   ncyc          = 0;
   int   last_cnv_rise = -1;
   logic prev_sck      = 1'b0;
   logic prev_cnv      = 1'b0;
   logic e_cnv, e_sck, e_stb;

   always @(negedge clk) begin
      ncyc++;
      if (!rst_n) begin
         check("reset_hold", {13'd0, cnv, sck, strobe, data}, 32'd0);
         rises = 0; strobes = 0; last_cnv_rise = -1;
         prev_sck = 1'b0; prev_cnv = 1'b0;
      end else if (cyc >= 0) begin
         e_cnv = (cyc < 140);
         e_sck = (cyc >= 140) && (cyc < 204) && (((cyc - 140) % 4) >= 2);
         e_stb = (cyc == 203);
         check($sformatf("cycle%0d", cyc), {13'd0, cnv, sck, strobe, data},
               {13'd0, e_cnv, e_sck, e_stb, exp_data});
         if (sck && !prev_sck) rises++;
         if (strobe) strobes++;
         if (cnv && !prev_cnv) begin
            if (last_cnv_rise >= 0) check("cnv_period", ncyc - last_cnv_rise, 210);
            last_cnv_rise = ncyc;
         end
         prev_sck = sck;
         prev_cnv = cnv;
         if (cyc == 209) begin
            check("sck_rises_per_frame", rises, 16);
            check("strobes_per_frame", strobes, 1);
            rises = 0;
            strobes = 0;
         end
      end
   end

   task automatic wait_cyc(input int target);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (cyc != target && n < 1000);
      check($sformatf("wait_cyc%0d", target), cyc, target);
   endtask

   initial begin
      logic [15:0] expect_word;
      logic [15:0] tp_expect = '0;
      logic [15:0] w;

      vecs[0] = '{16'hFFFF, -1, 16'hFFFF};
      vecs[1] = '{16'hA5C3, -1, 16'hA5C3};
      vecs[2] = '{16'h0000, -1, 16'h0000};
      for (int i = 3; i < 9; i++) begin
         w = 16'($urandom);
         vecs[i] = '{w, -1, w};
      end
      vecs[6].reset_at = 170;
      vecs[6].exp_word = 16'h0000;

      #1 rst_n = 1'b0;
      repeat (30) @(negedge clk);
      #2 rst_n = 1'b1;

      for (int i = 0; i < 9; i++) begin
         wait_cyc(0);
         cur_word = vecs[i].word;
         check("frame_start_cnv", cnv, 1'b1);
         if (vecs[i].reset_at >= 0) begin
            wait_cyc(vecs[i].reset_at);
            #2 rst_n = 1'b0;
            #1 check("async_reset_outputs", {13'd0, cnv, sck, strobe, data}, 32'd0);
            repeat (5) @(negedge clk);
            #2 rst_n = 1'b1;
            tp_expect = '0;
            check("word_after_reset", data, vecs[i].exp_word);
            $display("frame %0d: reset at cycle %0d, word %04h", i, vecs[i].reset_at, data);
         end else begin
            wait_cyc(203);
            check("strobe_at_203", strobe, 1'b1);
            wait_cyc(204);
`ifdef ADC_TEST_PATTERN_EN
            expect_word = tp_expect;
            tp_expect   = tp_expect + 16'd1;
`else
            expect_word = vecs[i].exp_word;
`endif
            check("word", data, expect_word);
            $display("frame %0d: sdo %04h, word %04h", i, vecs[i].word, data);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
